ram_port_arbiter: RTL and testbench

Shares the single PSRAM data port (ramData) between two masters: the CPU data path (m0) and a secondary master such as a DMA or bootloader copy engine (m1). Uses round-robin arbitration with one outstanding transaction at a time. The request and address phase is latched, so masters may change signals after completion. A watchdog aborts any slave transaction that never completes. Sits between the bus decode (ram_ren/ram_wen) and ramData.

---
 rtl/ram_port_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Shares the single PSRAM data port between the CPU data path (m0) and a
// secondary master (m1). Round-robin arbitration with one outstanding
// transaction. The winning request is latched into the slave-side registers
// at grant, so masters only have to keep requesting until their done pulse.
// A watchdog aborts a slave transaction that never completes. After every
// completion the arbiter spends one RELEASE cycle ignoring requests, which
// gives the finished master time to drop its request.
module ram_port_arbiter #(
   parameter int          ADDR_W   = 32,
   parameter int          TIMEOUT  = 1024,
   parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
   input  logic              clk,
   input  logic              reset,

   input  logic              m0_ren,
   input  logic              m0_wen,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [31:0]       m0_wdata,
   input  logic [3:0]        m0_be,
   output logic [31:0]       m0_rdata,
   output logic              m0_done,
   output logic              m0_err,

   input  logic              m1_ren,
   input  logic              m1_wen,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [31:0]       m1_wdata,
   input  logic [3:0]        m1_be,
   output logic [31:0]       m1_rdata,
   output logic              m1_done,
   output logic              m1_err,

   output logic              s_ren,
   output logic              s_wen,
   output logic [ADDR_W-1:0] s_addr,
   output logic [31:0]       s_wdata,
   output logic [3:0]        s_be,
   input  logic [31:0]       s_rdata,
   input  logic              s_done,

   output logic [1:0]        grant
);

   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY    = 2'd1,
      RELEASE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_nextState;
   logic             r_lastM1;
   logic [CNT_W-1:0] r_wdCount;

   logic             w_req0;
   logic             w_req1;
   logic             w_start;
   logic             w_pickM1;
   logic             w_complete;
   logic             w_abort;
   logic             w_selRen;
   logic             w_selWen;

   // Next-state and arbitration decision; s_done takes priority over the watchdog.
   always_comb begin
      w_nextState = r_state;
      w_start     = 1'b0;
      w_pickM1    = 1'b0;
      w_complete  = 1'b0;
      w_abort     = 1'b0;
      w_req0      = m0_ren | m0_wen;
      w_req1      = m1_ren | m1_wen;
      case (r_state)
         IDLE: begin
            if (w_req0 || w_req1) begin
               w_start     = 1'b1;
               w_pickM1    = (w_req0 && w_req1) ? ~r_lastM1 : w_req1;
               w_nextState = BUSY;
            end
         end
         BUSY: begin
            if (s_done) begin
               w_complete  = 1'b1;
               w_nextState = RELEASE;
            end else if (r_wdCount == LAST_CNT) begin
               w_abort     = 1'b1;
               w_nextState = RELEASE;
            end
         end
         RELEASE: begin
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
      w_selRen = w_pickM1 ? m1_ren : m0_ren;
      w_selWen = w_pickM1 ? m1_wen : m0_wen;
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Slave-side request latch and grant; strobes hold for the whole BUSY phase.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s_ren   <= 1'b0;
         s_wen   <= 1'b0;
         s_addr  <= '0;
         s_wdata <= '0;
         s_be    <= '0;
         grant   <= 2'b00;
      end else if (w_start) begin
         s_wen   <= w_selWen;
         s_ren   <= w_selRen & ~w_selWen;
         s_addr  <= w_pickM1 ? m1_addr  : m0_addr;
         s_wdata <= w_pickM1 ? m1_wdata : m0_wdata;
         s_be    <= w_pickM1 ? m1_be    : m0_be;
         grant   <= w_pickM1 ? 2'b10 : 2'b01;
      end else if (w_complete) begin
         s_ren   <= 1'b0;
         s_wen   <= 1'b0;
         grant   <= 2'b00;
      end else if (w_abort) begin
         s_ren   <= 1'b0;
         s_wen   <= 1'b0;
         s_addr  <= '0;
         s_wdata <= '0;
         s_be    <= '0;
         grant   <= 2'b00;
      end
   end

   // Watchdog: restarts on every grant and counts BUSY cycles.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wdCount <= '0;
      end else if (w_start) begin
         r_wdCount <= '0;
      end else if (r_state == BUSY && !w_abort) begin
         r_wdCount <= r_wdCount + CNT_W'(1);
      end
   end

   // Master-side results: one-cycle done/err pulses, read data held until the next read.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         m0_rdata <= '0;
         m0_done  <= 1'b0;
         m0_err   <= 1'b0;
         m1_rdata <= '0;
         m1_done  <= 1'b0;
         m1_err   <= 1'b0;
      end else begin
         m0_done <= 1'b0;
         m0_err  <= 1'b0;
         m1_done <= 1'b0;
         m1_err  <= 1'b0;
         if (w_complete || w_abort) begin
            if (grant[1]) begin
               m1_done <= 1'b1;
               m1_err  <= w_abort;
               if (s_ren) begin
                  m1_rdata <= w_abort ? ERR_DATA : s_rdata;
               end
            end else begin
               m0_done <= 1'b1;
               m0_err  <= w_abort;
               if (s_ren) begin
                  m0_rdata <= w_abort ? ERR_DATA : s_rdata;
               end
            end
         end
      end
   end

   // Round-robin memory: the owner of the last normally completed transaction.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_lastM1 <= 1'b1;
      end else if (w_complete) begin
         r_lastM1 <= grant[1];
      end
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed testbench for ram_port_arbiter with a short watchdog (TIMEOUT=8).
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_ram_port_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        m0_ren, m0_wen, m1_ren, m1_wen;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic [3:0]  m0_be, m1_be;
   logic [31:0] m0_rdata, m1_rdata;
   logic        m0_done, m0_err, m1_done, m1_err;
   logic        s_ren, s_wen, s_done;
   logic [31:0] s_addr, s_wdata, s_rdata;
   logic [3:0]  s_be;
   logic [1:0]  grant;

   int testsRun    = 0;
   int testsFailed = 0;

   ram_port_arbiter #(
      .ADDR_W   (32),
      .TIMEOUT  (8),
      .ERR_DATA (32'hDEADBEEF)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .m0_ren   (m0_ren),
      .m0_wen   (m0_wen),
      .m0_addr  (m0_addr),
      .m0_wdata (m0_wdata),
      .m0_be    (m0_be),
      .m0_rdata (m0_rdata),
      .m0_done  (m0_done),
      .m0_err   (m0_err),
      .m1_ren   (m1_ren),
      .m1_wen   (m1_wen),
      .m1_addr  (m1_addr),
      .m1_wdata (m1_wdata),
      .m1_be    (m1_be),
      .m1_rdata (m1_rdata),
      .m1_done  (m1_done),
      .m1_err   (m1_err),
      .s_ren    (s_ren),
      .s_wen    (s_wen),
      .s_addr   (s_addr),
      .s_wdata  (s_wdata),
      .s_be     (s_be),
      .s_rdata  (s_rdata),
      .s_done   (s_done),
      .grant    (grant)
   );

   // 10-unit clock.
   always #5 clk = ~clk;

   // Hard stop in case the sequence ever stalls.
   initial begin
      #100000;
      $display("[TB] FAIL global_timeout: simulation did not finish in time");
      $fatal(1, "[TB] simulation time limit reached");
   end

   // One comparison: counts it and reports observed/expected on failure.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic applyStimulus(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Linear directed sequence.
   initial begin
      reset = 1'b0;
      m0_ren = 0; m0_wen = 0; m0_addr = 0; m0_wdata = 0; m0_be = 0;
      m1_ren = 0; m1_wen = 0; m1_addr = 0; m1_wdata = 0; m1_be = 0;
      s_done = 0; s_rdata = 0;
      applyStimulus(2);

      // Reset state
      checkOutput("rst_grant", 32'(grant), 32'h0);
      checkOutput("rst_s_ren", 32'(s_ren), 32'h0);
      checkOutput("rst_s_wen", 32'(s_wen), 32'h0);
      checkOutput("rst_s_addr", s_addr, 32'h0);
      checkOutput("rst_m0_rdata", m0_rdata, 32'h0);
      checkOutput("rst_m0_done", 32'(m0_done), 32'h0);
      reset = 1'b1;
      applyStimulus(1);

      // Contention from reset: both write, m0 first, then alternation
      m0_wen = 1; m0_addr = 32'h200; m0_wdata = 32'h11111111; m0_be = 4'hF;
      m1_wen = 1; m1_addr = 32'h300; m1_wdata = 32'h22222222; m1_be = 4'hF;
      applyStimulus(1);
      checkOutput("cont1_grant", 32'(grant), 32'h1);
      checkOutput("cont1_s_wen", 32'(s_wen), 32'h1);
      checkOutput("cont1_s_ren", 32'(s_ren), 32'h0);
      checkOutput("cont1_s_addr", s_addr, 32'h200);
      checkOutput("cont1_s_wdata", s_wdata, 32'h11111111);
      s_done = 1;
      applyStimulus(1);
      s_done = 0;
      checkOutput("cont1_m0_done", 32'(m0_done), 32'h1);
      checkOutput("cont1_m1_done", 32'(m1_done), 32'h0);
      checkOutput("cont1_grant_rel", 32'(grant), 32'h0);
      applyStimulus(1);
      checkOutput("cont_idle_grant", 32'(grant), 32'h0);
      checkOutput("cont_idle_m0_done", 32'(m0_done), 32'h0);
      applyStimulus(1);
      checkOutput("cont2_grant", 32'(grant), 32'h2);
      checkOutput("cont2_s_addr", s_addr, 32'h300);
      checkOutput("cont2_s_wdata", s_wdata, 32'h22222222);
      s_done = 1;
      applyStimulus(1);
      s_done = 0;
      checkOutput("cont2_m1_done", 32'(m1_done), 32'h1);
      checkOutput("cont2_m0_done", 32'(m0_done), 32'h0);
      applyStimulus(2);
      checkOutput("cont3_grant", 32'(grant), 32'h1);
      s_done = 1;
      applyStimulus(1);
      s_done = 0;
      applyStimulus(2);
      checkOutput("cont4_grant", 32'(grant), 32'h2);
      s_done = 1;
      applyStimulus(1);
      s_done = 0;
      m0_wen = 0; m1_wen = 0;
      applyStimulus(1);

      // Single read on m0, slave answers in the second BUSY cycle
      m0_ren = 1; m0_addr = 32'h100;
      applyStimulus(1);
      checkOutput("rd_grant", 32'(grant), 32'h1);
      checkOutput("rd_s_ren", 32'(s_ren), 32'h1);
      checkOutput("rd_s_addr", s_addr, 32'h100);
      applyStimulus(1);
      checkOutput("rd_wait_done", 32'(m0_done), 32'h0);
      s_done = 1; s_rdata = 32'h12345678;
      applyStimulus(1);
      s_done = 0;
      checkOutput("rd_m0_done", 32'(m0_done), 32'h1);
      checkOutput("rd_m0_err", 32'(m0_err), 32'h0);
      checkOutput("rd_m0_rdata", m0_rdata, 32'h12345678);
      checkOutput("rd_grant_rel", 32'(grant), 32'h0);
      checkOutput("rd_s_ren_rel", 32'(s_ren), 32'h0);
      checkOutput("rd_m1_done", 32'(m1_done), 32'h0);
      checkOutput("rd_m1_rdata", m1_rdata, 32'h0);
      m0_ren = 0;
      applyStimulus(1);
      checkOutput("rd_done_pulse", 32'(m0_done), 32'h0);
      checkOutput("rd_rdata_hold", m0_rdata, 32'h12345678);

      // s_done in IDLE is ignored
      s_done = 1; s_rdata = 32'h99999999;
      applyStimulus(1);
      s_done = 0;
      applyStimulus(1);
      checkOutput("stray_m0_done", 32'(m0_done), 32'h0);
      checkOutput("stray_m0_rdata", m0_rdata, 32'h12345678);

      // m1 with ren+wen is a write; rdata untouched
      m1_ren = 1; m1_wen = 1; m1_addr = 32'h400; m1_wdata = 32'hAABBCCDD; m1_be = 4'b0011;
      applyStimulus(1);
      checkOutput("rw_grant", 32'(grant), 32'h2);
      checkOutput("rw_s_wen", 32'(s_wen), 32'h1);
      checkOutput("rw_s_ren", 32'(s_ren), 32'h0);
      checkOutput("rw_s_be", 32'(s_be), 32'h3);
      checkOutput("rw_s_wdata", s_wdata, 32'hAABBCCDD);
      s_done = 1; s_rdata = 32'h55555555;
      applyStimulus(1);
      s_done = 0;
      checkOutput("rw_m1_done", 32'(m1_done), 32'h1);
      checkOutput("rw_m1_rdata", m1_rdata, 32'h0);
      m1_ren = 0; m1_wen = 0;
      applyStimulus(1);

      // Timeout: 8 BUSY cycles without s_done
      m0_ren = 1; m0_addr = 32'h500;
      applyStimulus(8);
      checkOutput("to_busy8_s_ren", 32'(s_ren), 32'h1);
      checkOutput("to_busy8_done", 32'(m0_done), 32'h0);
      applyStimulus(1);
      checkOutput("to_m0_done", 32'(m0_done), 32'h1);
      checkOutput("to_m0_err", 32'(m0_err), 32'h1);
      checkOutput("to_m0_rdata", m0_rdata, 32'hDEADBEEF);
      checkOutput("to_s_ren", 32'(s_ren), 32'h0);
      checkOutput("to_grant", 32'(grant), 32'h0);
      m0_ren = 0;
      applyStimulus(1);
      checkOutput("to_err_pulse", 32'(m0_err), 32'h0);

      // s_done coinciding with the last watchdog count completes normally
      m0_ren = 1; m0_addr = 32'h600;
      applyStimulus(8);
      s_done = 1; s_rdata = 32'hCAFEF00D;
      applyStimulus(1);
      s_done = 0;
      checkOutput("col_m0_done", 32'(m0_done), 32'h1);
      checkOutput("col_m0_err", 32'(m0_err), 32'h0);
      checkOutput("col_m0_rdata", m0_rdata, 32'hCAFEF00D);
      m0_ren = 0;
      applyStimulus(1);

      // Asynchronous reset during BUSY, then m0 wins the next tie
      m1_ren = 1; m1_addr = 32'h700;
      applyStimulus(1);
      checkOutput("mr_grant_busy", 32'(grant), 32'h2);
      checkOutput("mr_s_ren_busy", 32'(s_ren), 32'h1);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("mr_s_ren", 32'(s_ren), 32'h0);
      checkOutput("mr_s_wen", 32'(s_wen), 32'h0);
      checkOutput("mr_grant", 32'(grant), 32'h0);
      checkOutput("mr_m1_done", 32'(m1_done), 32'h0);
      m0_ren = 1; m0_addr = 32'h800;
      reset = 1'b1;
      applyStimulus(1);
      checkOutput("mr_tie_grant", 32'(grant), 32'h1);
      checkOutput("mr_tie_s_addr", s_addr, 32'h800);
      s_done = 1; s_rdata = 32'h0BADF00D;
      applyStimulus(1);
      s_done = 0;
      checkOutput("mr_m0_done", 32'(m0_done), 32'h1);
      checkOutput("mr_m1_done_after", 32'(m1_done), 32'h0);
      m0_ren = 0; m1_ren = 0;
      applyStimulus(2);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
